// File: rtl/periph_hub.sv
// Keypad/display peripheral hub: register-mapped keypad FIFO, control/status
// and display registers behind a simple read/write strobe bus.
module periph_hub #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned KEY_W      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NUM_DISP   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          din,
  input  logic                       writeEnable,
  input  logic                       readEnable,
  output logic [DATA_W-1:0]          dout,
  input  logic [KEY_W-1:0]           key_code,
  input  logic                       key_valid,
  output logic [NUM_DISP*DATA_W-1:0] disp_out,
  output logic                       irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [KEY_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              ovf, ovf_nxt;
  logic              irq_en, irq_en_nxt;
  logic [DATA_W-1:0] disp_q [NUM_DISP];
  logic [DATA_W-1:0] rd_data;
  logic              empty, full;
  logic              rd_key, wr_ctrl, flush, ovf_clr;
  logic              pop, push, ovf_event;

  // Access decode and FIFO next-state; flush overrides any push/pop that cycle
  always_comb begin
    empty     = (count == CNT_W'(0));
    full      = (count == CNT_W'(FIFO_DEPTH));
    rd_key    = readEnable && (address == ADDR_W'(0));
    wr_ctrl   = writeEnable && (address == ADDR_W'(2));
    flush     = wr_ctrl && din[2];
    ovf_clr   = wr_ctrl && din[1];
    pop       = rd_key && !empty && !flush;
    push      = key_valid && (!full || pop) && !flush;
    ovf_event = key_valid && full && !pop && !flush;

    count_nxt = count;
    if (flush)
      count_nxt = CNT_W'(0);
    else if (push && !pop)
      count_nxt = count + CNT_W'(1);
    else if (pop && !push)
      count_nxt = count - CNT_W'(1);

    ovf_nxt = ovf;
    if (ovf_event)
      ovf_nxt = 1'b1;
    else if (ovf_clr)
      ovf_nxt = 1'b0;

    irq_en_nxt = wr_ctrl ? din[0] : irq_en;
  end

  // Read mux over pre-edge state
  always_comb begin
    rd_data = '0;
    if (address == ADDR_W'(0)) begin
      if (!empty)
        rd_data = DATA_W'(mem[rd_ptr]);
    end else if (address == ADDR_W'(1)) begin
      rd_data[0]         = empty;
      rd_data[1]         = full;
      rd_data[2]         = ovf;
      rd_data[3 +: CNT_W] = count;
    end else if (address == ADDR_W'(2)) begin
      rd_data[0] = irq_en;
    end
    for (int k = 0; k < int'(NUM_DISP); k++) begin
      if (address == ADDR_W'(4 + k))
        rd_data = disp_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
      dout   <= '0;
      for (int k = 0; k < int'(NUM_DISP); k++)
        disp_q[k] <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
      end
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      irq_en <= irq_en_nxt;
      irq    <= irq_en_nxt && (count_nxt != CNT_W'(0));
      dout   <= readEnable ? rd_data : '0;
      for (int k = 0; k < int'(NUM_DISP); k++) begin
        if (writeEnable && (address == ADDR_W'(4 + k)))
          disp_q[k] <= din;
      end
    end
  end

  // Storage array is not reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= key_code;
  end

  for (genvar k = 0; k < int'(NUM_DISP); k++) begin : g_disp
    assign disp_out[k*DATA_W +: DATA_W] = disp_q[k];
  end

endmodule

// File: tb/tb_periph_hub.sv
// Directed self-checking bench for periph_hub (default parameters).
module tb_periph_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic [31:0] din;
  logic        writeEnable;
  logic        readEnable;
  logic [31:0] dout;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [63:0] disp_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  periph_hub #(
    .DATA_W(32), .ADDR_W(4), .KEY_W(4), .FIFO_DEPTH(8), .NUM_DISP(2)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .din(din),
    .writeEnable(writeEnable), .readEnable(readEnable), .dout(dout),
    .key_code(key_code), .key_valid(key_valid), .disp_out(disp_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a; readEnable = 1'b1;
    tick();
    readEnable = 1'b0;
    d = dout;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; din = d; writeEnable = 1'b1;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic push(input logic [3:0] c);
    key_code = c; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  logic [31:0] r;
  logic [3:0]  drain_exp [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10};

  initial begin
    reset = 1'b0; address = '0; din = '0; writeEnable = 1'b0;
    readEnable = 1'b0; key_code = '0; key_valid = 1'b0;
    tick(); tick();
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_disp", disp_out, 64'h0);
    reset = 1'b1;
    tick();
    rd(4'd1, r); check("rst_status", 64'(r), 64'h1);

    // FIFO ordering
    push(4'd3); push(4'd7); push(4'd9);
    rd(4'd1, r); check("status_cnt3", 64'(r), 64'h18);
    rd(4'd0, r); check("pop_3", 64'(r), 64'd3);
    rd(4'd0, r); check("pop_7", 64'(r), 64'd7);
    rd(4'd0, r); check("pop_9", 64'(r), 64'd9);
    rd(4'd1, r); check("status_empty", 64'(r), 64'h1);
    rd(4'd0, r); check("pop_empty", 64'(r), 64'h0);
    rd(4'd1, r); check("status_after_empty_pop", 64'(r), 64'h1);

    // Overflow on the ninth push, then clear
    for (int i = 1; i <= 9; i++) push(4'(i));
    rd(4'd1, r); check("status_ovf", 64'(r), 64'h46);
    wr(4'd2, 32'h2);
    rd(4'd1, r); check("status_ovf_clr", 64'(r), 64'h42);

    // Full FIFO with simultaneous push and pop
    address = 4'd0; readEnable = 1'b1; key_code = 4'd10; key_valid = 1'b1;
    tick();
    readEnable = 1'b0; key_valid = 1'b0;
    check("full_pushpop_data", 64'(dout), 64'd1);
    rd(4'd1, r); check("full_pushpop_status", 64'(r), 64'h42);

    // Overflow set beats a same-cycle clear
    address = 4'd2; din = 32'h2; writeEnable = 1'b1; key_code = 4'd11; key_valid = 1'b1;
    tick();
    writeEnable = 1'b0; key_valid = 1'b0;
    rd(4'd1, r); check("ovf_set_wins", 64'(r), 64'h46);
    wr(4'd2, 32'h2);
    for (int i = 0; i < 8; i++) begin
      rd(4'd0, r); check($sformatf("drain_%0d", i), 64'(r), 64'(drain_exp[i]));
    end
    rd(4'd1, r); check("drained_status", 64'(r), 64'h1);

    // Push and pop together while empty: pop ignored
    address = 4'd0; readEnable = 1'b1; key_code = 4'd5; key_valid = 1'b1;
    tick();
    readEnable = 1'b0; key_valid = 1'b0;
    check("empty_pushpop_data", 64'(dout), 64'h0);
    rd(4'd1, r); check("empty_pushpop_status", 64'(r), 64'h8);
    rd(4'd0, r); check("empty_pushpop_pop", 64'(r), 64'd5);

    // Interrupt follows irq_en and occupancy with one cycle of lag
    wr(4'd2, 32'h1);
    check("irq_idle", 64'(irq), 64'h0);
    push(4'd6);
    check("irq_set", 64'(irq), 64'h1);
    rd(4'd2, r); check("ctrl_readback", 64'(r), 64'h1);
    rd(4'd0, r); check("irq_pop_data", 64'(r), 64'd6);
    check("irq_clear", 64'(irq), 64'h0);

    // Flush with a concurrent push
    for (int i = 1; i <= 5; i++) push(4'(i));
    rd(4'd1, r); check("status_cnt5", 64'(r), 64'h28);
    check("irq_cnt5", 64'(irq), 64'h1);
    address = 4'd2; din = 32'h5; writeEnable = 1'b1; key_code = 4'd12; key_valid = 1'b1;
    tick();
    writeEnable = 1'b0; key_valid = 1'b0;
    check("irq_after_flush", 64'(irq), 64'h0);
    rd(4'd1, r); check("status_flush", 64'(r), 64'h1);
    rd(4'd2, r); check("ctrl_pulses_read0", 64'(r), 64'h1);

    // Unmapped addresses
    wr(4'd3, 32'hFFFF_FFFF);
    rd(4'd3, r); check("unmapped_3", 64'(r), 64'h0);
    rd(4'd7, r); check("unmapped_7", 64'(r), 64'h0);

    // Display registers
    wr(4'd4, 32'hDEAD_BEEF);
    check("disp0_out", disp_out, 64'h0000_0000_DEAD_BEEF);
    wr(4'd5, 32'h1234_5678);
    check("disp_both", disp_out, 64'h1234_5678_DEAD_BEEF);
    rd(4'd4, r); check("disp0_read", 64'(r), 64'hDEAD_BEEF);
    rd(4'd5, r); check("disp1_read", 64'(r), 64'h1234_5678);
    tick();
    check("dout_idle_zero", 64'(dout), 64'h0);
    address = 4'd4; din = 32'h1111_1111; writeEnable = 1'b1; readEnable = 1'b1;
    tick();
    writeEnable = 1'b0; readEnable = 1'b0;
    check("rw_same_old", 64'(dout), 64'hDEAD_BEEF);
    rd(4'd4, r); check("rw_same_new", 64'(r), 64'h1111_1111);

    // Asynchronous reset mid-stream with a read in flight
    push(4'd9);
    check("irq_pre_reset", 64'(irq), 64'h1);
    address = 4'd5; readEnable = 1'b1;
    tick();
    check("dout_pre_reset", 64'(dout), 64'h1234_5678);
    #2 reset = 1'b0;
    #1;
    check("async_dout", 64'(dout), 64'h0);
    check("async_irq", 64'(irq), 64'h0);
    check("async_disp", disp_out, 64'h0);
    readEnable = 1'b0; key_code = 4'd4; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("post_reset_dout", 64'(dout), 64'h0);
    rd(4'd1, r); check("post_reset_status", 64'(r), 64'h1);
    rd(4'd2, r); check("post_reset_ctrl", 64'(r), 64'h0);
    rd(4'd0, r); check("post_reset_key", 64'(r), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_hub.md
PERIPH_HUB -- requirements
Module: periph_hub

Interface
REQ-001 Parameter DATA_W, default 32: bus data width, at least 16.
REQ-002 Parameter ADDR_W, default 4: word address width, at least 3.
REQ-003 Parameter KEY_W, default 4: keypad code width, less than DATA_W.
REQ-004 Parameter FIFO_DEPTH, default 8: keypad FIFO entries, power of 2, at least 2.
REQ-005 Parameter NUM_DISP, default 2: display registers, 1..4.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 address  in  ADDR_W  word address of the register access.
REQ-009 din  in  DATA_W  write data.
REQ-010 writeEnable  in  1  write strobe, sampled each clk.
REQ-011 readEnable  in  1  read strobe, sampled each clk.
REQ-012 dout  out  DATA_W  registered read data.
REQ-013 key_code  in  KEY_W  debounced key code from the keypad scanner.
REQ-014 key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-015 disp_out  out  NUM_DISP*DATA_W  display register contents; register k occupies slice [k*DATA_W +: DATA_W].
REQ-016 irq  out  1  registered interrupt, high while enabled and the FIFO is non-empty.

Function
REQ-017 Register map (word addresses):
- 0 KEYDATA (R): FIFO head, zero-extended.
- 1 STATUS (R).
- 2 CTRL (R/W).
- 4..4+NUM_DISP-1 DISPk (R/W).
- All other addresses read 0; writes to them are ignored.
REQ-018 STATUS bit fields:
- bit0 empty; bit1 full; bit2 overflow (sticky).
- bits[3+:log2(FIFO_DEPTH)+1] count.
- all other bits 0.
REQ-019 CTRL bit fields:
- bit0 irq_en: stored; reads back.
- bit1 ovf_clr: write-1 pulse, not stored, reads 0.
- bit2 flush: write-1 pulse, not stored, reads 0.
REQ-020 Read latency: dout is valid exactly 1 cycle after readEnable is sampled high, reflecting pre-edge state; dout is 0 the cycle after readEnable is sampled low.
REQ-021 Pop on read: a KEYDATA read while the FIFO is non-empty pops the head in the same edge. A KEYDATA read while empty returns 0 and changes no state.
REQ-022 Push: key_valid high writes key_code at the tail if the FIFO is not full.
REQ-023 Push while full without a simultaneous pop: key_code is dropped, overflow sets to 1, and contents are unchanged.
REQ-024 Push and pop in the same cycle, FIFO non-empty (including full): both take effect, count unchanged, and overflow is not set.
REQ-025 Push and pop in the same cycle, FIFO empty: the push takes effect and the pop is ignored; the read returns 0.
REQ-026 Flush: empties the FIFO (pointers and count to 0); a push or pop in the same cycle is discarded; overflow is unaffected.
REQ-027 Overflow clear: ovf_clr clears overflow; if an overflow event occurs in the same cycle, the set wins.
REQ-028 Pointers: read and write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-029 Display writes: a write to DISPk loads din in one cycle, and disp_out reflects it the following cycle. A write and a read of the same address in the same cycle returns the old value.
REQ-030 irq timing: irq is registered as irq_en AND NOT empty, evaluated on post-edge state, so it lags the causing event by 1 cycle.
REQ-031 Simultaneous readEnable and writeEnable: both are honoured; the read always uses pre-edge state.

Reset
REQ-032 reset low, asynchronously and regardless of clk, forces:
- dout=0, irq=0, all disp_out=0.
- FIFO empty, count=0, overflow=0, irq_en=0.
REQ-033 Reset asserted mid-operation discards all FIFO contents and any in-flight read. The first access after deassertion sees reset values.
REQ-034 Reset deassertion takes effect at the next rising clk edge; no key_valid strobe is captured while reset is low.

Verification
REQ-035 Push codes 3,7,9; read KEYDATA three times -> dout 3,7,9 (1-cycle latency); STATUS read -> empty=1, count=0.
REQ-036 FIFO_DEPTH=8: push 9 codes -> full=1, count=8, overflow=1, 9th code absent. Write CTRL=0x2 -> overflow=0.
REQ-037 FIFO full; key_valid coincides with a KEYDATA read -> oldest code returned, count stays 8, overflow stays 0.
REQ-038 Write CTRL=0x1, push one code -> irq=1 one cycle after the push. Pop -> irq=0 one cycle after the pop.
REQ-039 Write DISP0=0xDEADBEEF and DISP1=0x12345678 -> disp_out reflects both, reads return them. Pulse reset low mid-stream -> all outputs 0 immediately.
REQ-040 Write CTRL=0x4 in the same cycle as a key_valid push, with 5 entries queued -> count=0 and empty=1 afterwards.
